adc_capture_multi: RTL and testbench
====================================

Name: adc_capture_multi

Overview:
Parametrised successor to the single-channel ADC capture buffer. It captures NUM_CH ADC channels simultaneously into per-channel circular buffers and keeps a programmable pre-trigger window. Capture is gated by a sample-valid strobe. A single logical read port, offset from the oldest stored sample, serves downstream processing and readout.

Parameters:
- DATA_WIDTH, 12, bits per ADC sample.
- NUM_CH, 4, number of channels captured in lockstep (1..16).
- DEPTH_LOG2, 12, log2 of samples stored per channel. DEPTH = 2**DEPTH_LOG2.
- PRE_TRIG, 256, samples kept before the trigger (0..DEPTH-1).

Ports:
- adc_clock, in, 1: sole clock.
- reset, in, 1: asynchronous, active-low reset (asserted when 0).
- arm, in, 1: start or restart an acquisition.
- start_capture, in, 1: external trigger, level-sampled.
- adc_valid, in, 1: a sample is present on adc_data this cycle.
- adc_data, in, NUM_CH*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- busy, out, 1: acquisition in progress (state ARMED, WAIT_TRIG or POST).
- trig_ready, out, 1: pre-trigger window full (state WAIT_TRIG).
- capture_done, out, 1: buffer frozen and readable.
- read_ch, in, clog2(NUM_CH) (min 1): channel select.
- read_addr, in, DEPTH_LOG2: logical index. 0 = oldest sample; PRE_TRIG = trigger sample.
- read_data, out, DATA_WIDTH: registered read result.

Behaviour:
- Reset, asynchronous while reset=0:
  - state=IDLE; busy, trig_ready, capture_done, read_data = 0.
  - Pointers and counters = 0.
  - Buffer RAM is not cleared.
- A write occurs only when adc_valid=1 and state is ARMED, WAIT_TRIG or POST.
  - All channels are written at wr_ptr.
  - wr_ptr increments mod DEPTH (wraps DEPTH-1 -> 0).
- IDLE:
  - arm=1 moves to ARMED; wr_ptr and cnt clear to 0.
  - With PRE_TRIG=0, arm=1 goes directly to WAIT_TRIG.
- ARMED:
  - Each write increments cnt.
  - When the write takes cnt to PRE_TRIG, move to WAIT_TRIG next cycle.
  - start_capture is ignored in this state.
- WAIT_TRIG:
  - The buffer keeps wrapping.
  - A trigger is start_capture=1 AND adc_valid=1 in the same cycle. That cycle's sample is the trigger sample.
  - On trigger: trig_ptr latches wr_ptr, post_cnt is set to 1, move to POST.
  - With DEPTH-PRE_TRIG=1, a trigger goes directly to DONE.
- POST:
  - Each write increments post_cnt.
  - When post_cnt reaches DEPTH-PRE_TRIG, move to DONE. The total written after the trigger, including the trigger sample, is DEPTH-PRE_TRIG.
- DONE:
  - No writes occur. capture_done=1 and busy=0.
  - arm=1 returns to ARMED (or WAIT_TRIG if PRE_TRIG=0). capture_done drops the following cycle.
- arm while busy is ignored (no restart mid-acquisition).
- Read path:
  - Physical address = (trig_ptr - PRE_TRIG + read_addr) mod DEPTH.
  - read_data is registered with 1-cycle latency from read_ch/read_addr.
  - read_data = 0 when capture_done=0.
  - read_ch >= NUM_CH returns 0.
- Simultaneous start_capture and arm in IDLE/DONE: arm wins and start_capture is ignored.
- Reset mid-acquisition aborts immediately. Stale RAM content is not reported because capture_done=0.

Optional Feature:
ADC_CAPTURE_THRESH_TRIG_EN.
- When defined, two extra inputs are added:
  - trig_level[DATA_WIDTH-1:0]
  - trig_src[clog2(NUM_CH)-1:0]
- An internal rising-edge trigger also fires in WAIT_TRIG when the selected channel crosses trig_level upward:
  - previous valid sample < trig_level AND current valid sample >= trig_level, unsigned compare.
  - The crossing is ORed with start_capture, with the same adc_valid qualification.
- The previous-sample register updates on every adc_valid in any state. Reset value is all-ones, so no false trigger occurs on the first sample.
- When not defined, the ports, compare logic and register are absent; only start_capture triggers.

Test Plan:
1. NUM_CH=2, DEPTH_LOG2=4, PRE_TRIG=4:
   - Stimulus: arm, continuous adc_valid, ch0=ramp from 0, ch1=ramp+100. start_capture with sample 20.
   - Required: capture_done after 12 valid samples including 20. ch0 read_addr 0..15 returns 16..31; ch1 returns 116..131.
2. Same config:
   - Stimulus: start_capture held high from arm.
   - Required: trigger ignored during ARMED; trig_ready after 4 samples. Trigger sample = 4, so read_addr 0 returns 0 and read_addr 15 returns 15.
3. Same config, adc_valid toggled 1-in-3 with start_capture pulsed while adc_valid=0:
   - Required: no trigger. Next start_capture with adc_valid=1 triggers, and the decimated data reads back correctly.
4. Stimulus: reset=0 asserted mid-POST.
   - Required: busy, capture_done and read_data = 0 immediately. After reset release and arm, a fresh capture completes correctly.
5. PRE_TRIG=0 and PRE_TRIG=15 edge configs:
   - PRE_TRIG=0: trigger sample at read_addr 0.
   - PRE_TRIG=15: DONE on the trigger cycle+1 and trigger sample at read_addr 15.
   - arm in DONE restarts; arm during POST is ignored.
6. With ADC_CAPTURE_THRESH_TRIG_EN, trig_level=50, trig_src=1:
   - Stimulus: ch1 ramp 40..60.
   - Required: trigger at ch1 sample 50. A ch1 sample sequence 60, 49, 51 triggers at 51.

Source files
------------

// File: rtl/adc_capture_multi.sv
// adc_capture_multi: multi-channel ADC capture into circular buffers with a pre-trigger window.
// Optional feature macro: ADC_CAPTURE_THRESH_TRIG_EN adds a rising-edge threshold trigger.
module adc_capture_multi #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter int PRE_TRIG = 256
) (
  input  logic                                       adc_clock,
  input  logic                                       reset,
  input  logic                                       arm,
  input  logic                                       start_capture,
  input  logic                                       adc_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]               adc_data,
`ifdef ADC_CAPTURE_THRESH_TRIG_EN
  input  logic [DATA_WIDTH-1:0]                      trig_level,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] trig_src,
`endif
  output logic                                       busy,
  output logic                                       trig_ready,
  output logic                                       capture_done,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] read_ch,
  input  logic [DEPTH_LOG2-1:0]                      read_addr,
  output logic [DATA_WIDTH-1:0]                      read_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] IDLE = 3'd0, ARMED = 3'd1, WAIT_TRIG = 3'd2, POST = 3'd3, DONE = 3'd4;
  localparam logic [2:0] ARM_ST = (PRE_TRIG == 0) ? WAIT_TRIG : ARMED;
  localparam logic [DEPTH_LOG2-1:0] PRE = DEPTH_LOG2'(PRE_TRIG);
  localparam logic [DEPTH_LOG2:0] POST_LEN = (DEPTH_LOG2+1)'(DEPTH - PRE_TRIG);
  logic [2:0] state;
  logic [DEPTH_LOG2-1:0] wr_ptr, cnt, trig_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] post_cnt;
  logic [NUM_CH*DATA_WIDTH-1:0] mem [DEPTH];
  logic wr_en, hit, trig;
  assign busy = state == ARMED || state == WAIT_TRIG || state == POST;
  assign trig_ready = state == WAIT_TRIG;
  assign capture_done = state == DONE;
  assign wr_en = adc_valid && busy;
  assign trig = adc_valid && (start_capture || hit);
  assign rd_ptr = trig_ptr - PRE + read_addr;
`ifdef ADC_CAPTURE_THRESH_TRIG_EN
  logic [DATA_WIDTH-1:0] prev, cur;
  assign cur = adc_data[int'(trig_src)*DATA_WIDTH +: DATA_WIDTH];
  assign hit = prev < trig_level && cur >= trig_level;
  // previous sample of the selected channel; all-ones so the first sample can never look like a crossing
  always_ff @(posedge adc_clock or negedge reset)
    if (!reset) prev <= '1;
    else if (adc_valid) prev <= cur;
`else
  assign hit = 1'b0;
`endif
  // acquisition sequencing: pre-trigger fill, trigger wait, post-trigger fill, freeze
  always_ff @(posedge adc_clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      cnt <= '0;
      trig_ptr <= '0;
      post_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      case (state)
        IDLE, DONE: if (arm) begin
          state <= ARM_ST;
          wr_ptr <= '0;
          cnt <= '0;
        end
        ARMED: if (adc_valid) begin
          cnt <= cnt + DEPTH_LOG2'(1);
          if (cnt + DEPTH_LOG2'(1) == PRE) state <= WAIT_TRIG;
        end
        WAIT_TRIG: if (trig) begin
          trig_ptr <= wr_ptr;
          post_cnt <= (DEPTH_LOG2+1)'(1);
          state <= (POST_LEN == (DEPTH_LOG2+1)'(1)) ? DONE : POST;
        end
        POST: if (adc_valid) begin
          post_cnt <= post_cnt + (DEPTH_LOG2+1)'(1);
          if (post_cnt + (DEPTH_LOG2+1)'(1) == POST_LEN) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  // sample storage: all channels share one word per slot and are never cleared
  always_ff @(posedge adc_clock)
    if (wr_en) mem[wr_ptr] <= adc_data;
  // registered read, relative to the oldest retained sample, gated by capture_done
  always_ff @(posedge adc_clock or negedge reset)
    if (!reset) read_data <= '0;
    else read_data <= (capture_done && int'(read_ch) < NUM_CH) ? mem[rd_ptr][int'(read_ch)*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_adc_capture_multi.sv
// tb_adc_capture_multi: directed bench for adc_capture_multi with PRE_TRIG 4, 0 and 15 instances.
module tb_adc_capture_multi;
  localparam int DW = 12;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0, arm = 1'b0, start = 1'b0, valid = 1'b0, read_ch = 1'b0;
  logic [2*DW-1:0] data = '0;
  logic [3:0] read_addr = '0;
  logic [2:0] bsy, trdy, dn;
  logic [2:0][DW-1:0] rdv;
`ifdef ADC_CAPTURE_THRESH_TRIG_EN
  logic [DW-1:0] lvl = '0;
  logic src = 1'b0;
`endif
  int checks = 0, errors = 0, s = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adc_capture_multi #(.DATA_WIDTH(DW), .NUM_CH(2), .DEPTH_LOG2(4),
                        .PRE_TRIG(g == 0 ? 4 : g == 1 ? 0 : 15)) dut (
      .adc_clock(clk), .reset(reset), .arm(arm), .start_capture(start),
      .adc_valid(valid), .adc_data(data),
`ifdef ADC_CAPTURE_THRESH_TRIG_EN
      .trig_level(lvl), .trig_src(src),
`endif
      .busy(bsy[g]), .trig_ready(trdy[g]), .capture_done(dn[g]),
      .read_ch(read_ch), .read_addr(read_addr), .read_data(rdv[g]));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push_raw(input int c0, input int c1, input logic st);
    valid = 1'b1;
    start = st;
    data = {DW'(c1), DW'(c0)};
    cyc();
  endtask

  task automatic push(input logic st);
    push_raw(s, s + 100, st);
    s++;
  endtask

  task automatic stream(input int n, input int t);
    repeat (n) push(s == t);
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    arm = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    s = 0;
  endtask

  task automatic do_arm;
    arm = 1'b1;
    valid = 1'b0;
    cyc();
    arm = 1'b0;
  endtask

  task automatic rd(input int k, input logic ch, input int a, input int exp, input string tag);
    read_ch = ch;
    read_addr = 4'(a);
    cyc();
    check($sformatf("%s ch%0d[%0d]", tag, ch, a), 32'(rdv[k]), exp);
  endtask

  initial begin
    cyc();
    check("rst busy", 32'(bsy[0]), 0);
    check("rst trdy", 32'(trdy[0]), 0);
    check("rst done", 32'(dn[0]), 0);
    check("rst rdata", 32'(rdv[0]), 0);
    reset = 1'b1;
    cyc();

    // basic ramp capture, trigger at sample 20
    do_arm();
    check("t1 busy", 32'(bsy[0]), 1);
    check("t1 trdy armed", 32'(trdy[0]), 0);
    stream(4, -1);
    check("t1 trdy", 32'(trdy[0]), 1);
    stream(16, -1);
    stream(1, 20);
    check("t1 post", 32'(trdy[0]), 0);
    stream(10, -1);
    check("t1 not done", 32'(dn[0]), 0);
    stream(1, -1);
    check("t1 done", 32'(dn[0]), 1);
    check("t1 idle busy", 32'(bsy[0]), 0);
    for (int a = 0; a < 16; a++) begin
      rd(0, 1'b0, a, 16 + a, "t1");
      rd(0, 1'b1, a, 116 + a, "t1");
    end

    // trigger held from arm is ignored until the window is full
    do_reset();
    start = 1'b1;
    do_arm();
    for (int i = 0; i < 3; i++) push(1'b1);
    check("t2 trdy early", 32'(trdy[0]), 0);
    push(1'b1);
    check("t2 trdy", 32'(trdy[0]), 1);
    check("t2 rdata gated", 32'(rdv[0]), 0);
    for (int i = 0; i < 11; i++) push(1'b1);
    check("t2 not done", 32'(dn[0]), 0);
    push(1'b1);
    check("t2 done", 32'(dn[0]), 1);
    start = 1'b0;
    valid = 1'b0;
    rd(0, 1'b0, 0, 0, "t2");
    rd(0, 1'b0, 4, 4, "t2");
    rd(0, 1'b0, 15, 15, "t2");
    rd(0, 1'b1, 4, 104, "t2");

    // decimated stream, start pulses without valid must not trigger
    do_reset();
    do_arm();
    for (int c = 0; c < 64; c++) begin
      valid = (c % 3 == 0);
      start = (c == 10 || c == 11 || c == 13 || c == 30);
      data = {DW'(c + 100), DW'(c)};
      cyc();
      if (c == 20) check("t3 no trig", 32'(trdy[0]), 1);
      if (c == 62) check("t3 not done", 32'(dn[0]), 0);
      if (c == 63) check("t3 done", 32'(dn[0]), 1);
    end
    valid = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 16; a++) rd(0, 1'b0, a, 18 + 3 * a, "t3");
    rd(0, 1'b1, 9, 145, "t3");

    // async reset clears outputs immediately, including a live read result
    rd(0, 1'b0, 15, 63, "t4 pre");
    reset = 1'b0;
    #1;
    check("t4 rst rdata", 32'(rdv[0]), 0);
    check("t4 rst done", 32'(dn[0]), 0);
    cyc();
    reset = 1'b1;
    cyc();
    s = 0;
    do_arm();
    stream(20, -1);
    stream(1, 20);
    stream(3, -1);
    check("t4 in post", 32'(bsy[0]), 1);
    reset = 1'b0;
    #1;
    check("t4 abort busy", 32'(bsy[0]), 0);
    check("t4 abort done", 32'(dn[0]), 0);
    check("t4 abort rdata", 32'(rdv[0]), 0);
    cyc();
    reset = 1'b1;
    cyc();
    s = 0;
    do_arm();
    stream(20, -1);
    stream(1, 20);
    stream(11, -1);
    check("t4 done", 32'(dn[0]), 1);
    rd(0, 1'b0, 0, 16, "t4");
    rd(0, 1'b0, 4, 20, "t4");
    rd(0, 1'b1, 15, 131, "t4");

    // PRE_TRIG=0 and PRE_TRIG=15, rearm in DONE, arm in POST ignored
    do_reset();
    do_arm();
    check("t5 pt0 trdy", 32'(trdy[1]), 1);
    check("t5 pt15 armed", 32'(trdy[2]), 0);
    check("t5 pt15 busy", 32'(bsy[2]), 1);
    stream(20, -1);
    check("t5 pt15 trdy", 32'(trdy[2]), 1);
    check("t5 pt15 not done", 32'(dn[2]), 0);
    stream(1, 20);
    check("t5 pt15 done", 32'(dn[2]), 1);
    check("t5 pt15 idle", 32'(bsy[2]), 0);
    check("t5 pt0 post", 32'(bsy[1]), 1);
    rd(2, 1'b0, 0, 5, "t5 pt15");
    rd(2, 1'b0, 10, 15, "t5 pt15");
    rd(2, 1'b0, 15, 20, "t5 pt15");
    rd(2, 1'b1, 15, 120, "t5 pt15");
    stream(4, -1);
    arm = 1'b1;
    push(1'b0);
    arm = 1'b0;
    check("t5 pt15 rearm done", 32'(dn[2]), 0);
    check("t5 pt15 rearm busy", 32'(bsy[2]), 1);
    check("t5 pt15 rearm trdy", 32'(trdy[2]), 0);
    check("t5 pt0 arm ignored", 32'(bsy[1]), 1);
    check("t5 pt0 still post", 32'(trdy[1]), 0);
    stream(9, -1);
    check("t5 pt0 not done", 32'(dn[1]), 0);
    stream(1, -1);
    check("t5 pt0 done", 32'(dn[1]), 1);
    rd(1, 1'b0, 0, 20, "t5 pt0");
    rd(1, 1'b0, 7, 27, "t5 pt0");
    rd(1, 1'b0, 15, 35, "t5 pt0");
    rd(1, 1'b1, 0, 120, "t5 pt0");

`ifdef ADC_CAPTURE_THRESH_TRIG_EN
    // threshold crossing on channel 1
    do_reset();
    lvl = DW'(50);
    src = 1'b1;
    do_arm();
    for (int j = 0; j < 22; j++) begin
      push_raw(j, 40 + j, 1'b0);
      if (j == 9) check("t6 waiting", 32'(trdy[0]), 1);
      if (j == 10) check("t6 fired", 32'(trdy[0]), 0);
      if (j == 20) check("t6 not done", 32'(dn[0]), 0);
      if (j == 21) check("t6 done", 32'(dn[0]), 1);
    end
    valid = 1'b0;
    rd(0, 1'b1, 4, 50, "t6");
    rd(0, 1'b0, 4, 10, "t6");
    rd(0, 1'b1, 0, 46, "t6");
    do_reset();
    do_arm();
    for (int j = 0; j < 4; j++) push_raw(j, 70 + j, 1'b0);
    push_raw(4, 60, 1'b0);
    check("t6 no trig 60", 32'(trdy[0]), 1);
    push_raw(5, 49, 1'b0);
    check("t6 no trig 49", 32'(trdy[0]), 1);
    push_raw(6, 51, 1'b0);
    check("t6 trig 51", 32'(trdy[0]), 0);
    check("t6 busy 51", 32'(bsy[0]), 1);
    for (int j = 7; j < 18; j++) push_raw(j, 200 + j, 1'b0);
    valid = 1'b0;
    check("t6 done2", 32'(dn[0]), 1);
    rd(0, 1'b1, 4, 51, "t6b");
    rd(0, 1'b1, 3, 49, "t6b");
    rd(0, 1'b0, 4, 6, "t6b");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
